bridge2xheep_rw: RTL and testbench

Parametrised MCU-to-OBI master bridge that sits between the CW305 register file and the X-HEEP OBI slave port. The MCU side pushes read/write commands into a DEPTH-entry command FIFO, and the bridge issues them as OBI transactions in order, with at most one outstanding transaction. Addresses come from an auto-incrementing pointer that the MCU can reload. Read data is captured in a sticky response register, with an overrun flag, until the MCU acknowledges it.

---
 rtl/bridge2xheep_rw_if.sv | 33 +++
 rtl/bridge2xheep_rw.sv | 257 +++++++++++++++++++++++++
 tb/tb_bridge2xheep_rw.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge2xheep_rw_if.sv
// +----------------------------------------------------------------------+
// | bridge2xheep_rw_if : OBI request/response bundle                       |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
`default_nettype none

interface bridge2xheep_rw_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  req;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/bridge2xheep_rw.sv
// +----------------------------------------------------------------------+
// | bridge2xheep_rw : MCU command FIFO to OBI master bridge, one request   |
// | outstanding. Optional watchdog: define BRIDGE2XHEEP_TIMEOUT_EN.        |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module bridge2xheep_rw #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    DEPTH          = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR     = ADDR_WIDTH'(32'h0000_0180),
    parameter int                    ADDR_STEP      = 4,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    bridge2xheep_rw_if.master              obi,
    input  wire logic                      cmd_valid,
    input  wire logic                      cmd_we,
    input  wire logic [DATA_WIDTH/8-1:0]   cmd_be,
    input  wire logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  wire logic                      base_load,
    input  wire logic [ADDR_WIDTH-1:0]     base_addr,
    input  wire logic                      rsp_ack,
    output logic                           busy,
    output logic                           fifo_full,
    output logic [$clog2(DEPTH):0]         fifo_count,
    output logic                           cmd_drop,
    output logic                           rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_overrun,
    output logic [ADDR_WIDTH-1:0]          cur_addr
`ifdef BRIDGE2XHEEP_TIMEOUT_EN
    ,
    output logic                           timeout_err
`endif
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int ENTRY_W  = 1 + ADDR_WIDTH + BE_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic                   is_read_q, is_read_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_overrun_q, rsp_overrun_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   cmd_drop_q, cmd_drop_d;

    logic [ENTRY_W-1:0]     fifo_mem [DEPTH];
    logic [ENTRY_W-1:0]     head;
    logic                   head_we;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [BE_WIDTH-1:0]    head_be;
    logic [DATA_WIDTH-1:0]  head_wdata;

    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   rsp_capture;
    logic                   timeout_hit;

    assign full = (count_q == FULL_COUNT);
    assign push = cmd_valid && !full;
    assign head = fifo_mem[rd_ptr_q];
    assign {head_we, head_addr, head_be, head_wdata} = head;

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef BRIDGE2XHEEP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             tmo_fire;

    assign timeout_hit = (state_q != ST_IDLE) &&
                         (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    // A grant or response in the final cycle still completes normally.
    assign tmo_fire = timeout_hit &&
                      ((state_q == ST_REQ) ? !obi.gnt : !obi.rvalid);

    always_comb begin
        tmo_cnt_d     = tmo_cnt_q + TMO_W'(1);
        timeout_err_d = timeout_err_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            tmo_cnt_d = '0;
        end
        if (tmo_fire) begin
            timeout_err_d = 1'b1;
        end else if (rsp_ack) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_tmo;

    assign timeout_hit = 1'b0;
    assign unused_tmo  = |TIMEOUT_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Transaction FSM and OBI outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        is_read_d = is_read_q;
        obi.req   = 1'b0;
        obi.we    = 1'b0;
        obi.be    = '0;
        obi.addr  = '0;
        obi.wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                obi.req   = 1'b1;
                obi.we    = head_we;
                obi.be    = head_be;
                obi.addr  = head_addr;
                obi.wdata = head_wdata;
                if (obi.gnt) begin
                    pop       = 1'b1;
                    is_read_d = !head_we;
                    state_d   = ST_WAIT_RSP;
                end else if (timeout_hit) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RSP: begin
                // No pop can happen here, so count_q plus a same-cycle push is the next occupancy.
                if (obi.rvalid) begin
                    state_d = ((count_q != '0) || push) ? ST_REQ : ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping and address pointer
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        cmd_drop_d = cmd_valid && full;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ptr_d = ptr_q;
        if (base_load) begin
            ptr_d = base_addr;
        end else if (push) begin
            ptr_d = ptr_q + ADDR_WIDTH'(ADDR_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_we, ptr_q, cmd_be, cmd_wdata};
        end
    end

    // ------------------------------------------------------------------
    // Read response capture
    // ------------------------------------------------------------------
    assign rsp_capture = (state_q == ST_WAIT_RSP) && obi.rvalid && is_read_q;

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_overrun_d = rsp_overrun_q;
        rsp_rdata_d   = rsp_rdata_q;
        if (rsp_capture) begin
            rsp_rdata_d   = obi.rdata;
            rsp_valid_d   = 1'b1;
            rsp_overrun_d = rsp_ack ? 1'b0 : (rsp_overrun_q || rsp_valid_q);
        end else if (rsp_ack) begin
            rsp_valid_d   = 1'b0;
            rsp_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ptr_q         <= RESET_ADDR;
            is_read_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_overrun_q <= 1'b0;
            rsp_rdata_q   <= '0;
            cmd_drop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ptr_q         <= ptr_d;
            is_read_q     <= is_read_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_overrun_q <= rsp_overrun_d;
            rsp_rdata_q   <= rsp_rdata_d;
            cmd_drop_q    <= cmd_drop_d;
        end
    end

    assign busy        = (count_q != '0) || (state_q != ST_IDLE);
    assign fifo_full   = full;
    assign fifo_count  = count_q;
    assign cmd_drop    = cmd_drop_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_overrun = rsp_overrun_q;
    assign cur_addr    = ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_bridge2xheep_rw.sv
// +----------------------------------------------------------------------+
// | tb_bridge2xheep_rw : directed self-checking bench for bridge2xheep_rw  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bridge2xheep_rw;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_we;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        base_load;
    logic [31:0] base_addr;
    logic        rsp_ack;
    logic        busy;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        cmd_drop;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_overrun;
    logic [31:0] cur_addr;
`ifdef BRIDGE2XHEEP_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bridge2xheep_rw_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) obi_if ();

    bridge2xheep_rw #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .DEPTH          (4),
        .RESET_ADDR     (32'h0000_0180),
        .ADDR_STEP      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .obi         (obi_if.master),
        .cmd_valid   (cmd_valid),
        .cmd_we      (cmd_we),
        .cmd_be      (cmd_be),
        .cmd_wdata   (cmd_wdata),
        .base_load   (base_load),
        .base_addr   (base_addr),
        .rsp_ack     (rsp_ack),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .fifo_count  (fifo_count),
        .cmd_drop    (cmd_drop),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_overrun (rsp_overrun),
        .cur_addr    (cur_addr)
`ifdef BRIDGE2XHEEP_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [3:0] be, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_be    = be;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!obi_if.req && n < 20) begin
            tick();
            n++;
        end
        check_eq("wait_req", obi_if.req, 1'b1);
    endtask

    task automatic serve(input logic [31:0] rd, input logic ack, input logic [31:0] exp_addr);
        wait_req();
        check_eq("serve_addr", obi_if.addr, exp_addr);
        obi_if.gnt = 1'b1;
        tick();
        obi_if.gnt    = 1'b0;
        obi_if.rvalid = 1'b1;
        obi_if.rdata  = rd;
        rsp_ack       = ack;
        tick();
        obi_if.rvalid = 1'b0;
        rsp_ack       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_be = '0; cmd_wdata = '0;
        base_load = 1'b0; base_addr = '0; rsp_ack = 1'b0;
        obi_if.gnt = 1'b0; obi_if.rvalid = 1'b0; obi_if.rdata = '0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_req",       obi_if.req, 1'b0);
        check_eq("rst_addr",      obi_if.addr, 32'h0);
        check_eq("rst_count",     fifo_count, 3'd0);
        check_eq("rst_cur_addr",  cur_addr, 32'h180);
        check_eq("rst_busy",      busy, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single write, granted on first request cycle
        push(1'b1, 4'hF, 32'hDEAD_BEEF);
        check_eq("w_count",    fifo_count, 3'd1);
        check_eq("w_cur_addr", cur_addr, 32'h184);
        check_eq("w_busy",     busy, 1'b1);
        check_eq("w_req_lat",  obi_if.req, 1'b0);
        tick();
        check_eq("w_req",   obi_if.req, 1'b1);
        check_eq("w_addr",  obi_if.addr, 32'h180);
        check_eq("w_we",    obi_if.we, 1'b1);
        check_eq("w_be",    obi_if.be, 4'hF);
        check_eq("w_wdata", obi_if.wdata, 32'hDEAD_BEEF);
        obi_if.gnt = 1'b1;
        tick();
        obi_if.gnt = 1'b0;
        check_eq("w_req_drop", obi_if.req, 1'b0);
        check_eq("w_we_idle",  obi_if.we, 1'b0);
        obi_if.rvalid = 1'b1;
        tick();
        obi_if.rvalid = 1'b0;
        check_eq("w_busy_end",  busy, 1'b0);
        check_eq("w_rsp_valid", rsp_valid, 1'b0);

        // base_load then read with five wait cycles
        base_load = 1'b1; base_addr = 32'h2000;
        tick();
        base_load = 1'b0;
        check_eq("bl_cur_addr", cur_addr, 32'h2000);
        push(1'b0, 4'hF, 32'h0);
        check_eq("r_cur_addr", cur_addr, 32'h2004);
        tick();
        for (int i = 0; i < 6; i++) begin
            check_eq("r_req_hold",  obi_if.req, 1'b1);
            check_eq("r_addr_hold", obi_if.addr, 32'h2000);
            if (i == 5) obi_if.gnt = 1'b1;
            tick();
        end
        obi_if.gnt = 1'b0; obi_if.rvalid = 1'b1; obi_if.rdata = 32'h1234_5678;
        tick();
        obi_if.rvalid = 1'b0;
        check_eq("r_rsp_valid", rsp_valid, 1'b1);
        check_eq("r_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check_eq("r_overrun",   rsp_overrun, 1'b0);
        rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
        check_eq("r_ack_clear", rsp_valid, 1'b0);

        // Fill past DEPTH with no grant
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_be = 4'h3;
        for (int i = 0; i < 5; i++) begin
            cmd_wdata = 32'(i);
            tick();
            if (i == 3) begin
                check_eq("f_full",     fifo_full, 1'b1);
                check_eq("f_count",    fifo_count, 3'd4);
                check_eq("f_no_drop",  cmd_drop, 1'b0);
            end
        end
        cmd_valid = 1'b0;
        check_eq("f_drop",       cmd_drop, 1'b1);
        check_eq("f_cur_addr",   cur_addr, 32'h2014);
        check_eq("f_count_hold", fifo_count, 3'd4);
        tick();
        check_eq("f_drop_pulse", cmd_drop, 1'b0);
        for (int i = 0; i < 4; i++) serve(32'h0, 1'b0, 32'h2004 + 32'(4 * i));
        check_eq("f_drain_busy", busy, 1'b0);

        // Overrun on two unacknowledged reads
        push(1'b0, 4'hF, 32'h0);
        push(1'b0, 4'hF, 32'h0);
        serve(32'hAAAA_0001, 1'b0, 32'h2014);
        serve(32'hBBBB_0002, 1'b0, 32'h2018);
        check_eq("o_valid",   rsp_valid, 1'b1);
        check_eq("o_overrun", rsp_overrun, 1'b1);
        check_eq("o_rdata",   rsp_rdata, 32'hBBBB_0002);
        rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
        check_eq("o_ack_valid",   rsp_valid, 1'b0);
        check_eq("o_ack_overrun", rsp_overrun, 1'b0);

        // Capture in the same cycle as ack wins
        push(1'b0, 4'hF, 32'h0);
        serve(32'h1111_0001, 1'b0, 32'h201C);
        push(1'b0, 4'hF, 32'h0);
        serve(32'h2222_0002, 1'b1, 32'h2020);
        check_eq("a_valid",   rsp_valid, 1'b1);
        check_eq("a_overrun", rsp_overrun, 1'b0);
        check_eq("a_rdata",   rsp_rdata, 32'h2222_0002);
        rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;

        // Push and pop on the same edge
        push(1'b1, 4'h1, 32'h55);
        wait_req();
        obi_if.gnt = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_be = 4'h2; cmd_wdata = 32'h66;
        tick();
        obi_if.gnt = 1'b0; cmd_valid = 1'b0;
        check_eq("pp_count", fifo_count, 3'd1);
        obi_if.rvalid = 1'b1;
        tick();
        obi_if.rvalid = 1'b0;
        check_eq("pp_next_be", obi_if.be, 4'h2);
        serve(32'h0, 1'b0, 32'h2028);
        check_eq("pp_busy", busy, 1'b0);

        // Reset while waiting for a response with two entries queued
        push(1'b1, 4'hF, 32'h1);
        push(1'b1, 4'hF, 32'h2);
        push(1'b1, 4'hF, 32'h3);
        wait_req();
        obi_if.gnt = 1'b1;
        tick();
        obi_if.gnt = 1'b0;
        check_eq("x_count_pre", fifo_count, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("x_req",      obi_if.req, 1'b0);
        check_eq("x_count",    fifo_count, 3'd0);
        check_eq("x_cur_addr", cur_addr, 32'h180);
        check_eq("x_busy",     busy, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        check_eq("x_req_after", obi_if.req, 1'b0);

`ifdef BRIDGE2XHEEP_TIMEOUT_EN
        // Request never granted: dropped after 16 cycles, next entry issued
        begin
            int n = 0;
            push(1'b1, 4'hF, 32'hA);
            push(1'b1, 4'hF, 32'hB);
            while (obi_if.req && n < 40) begin
                n++;
                tick();
            end
            check_eq("t_req_cycles", 64'(n), 64'd16);
            check_eq("t_err",        timeout_err, 1'b1);
            check_eq("t_count",      fifo_count, 3'd1);
            tick();
            check_eq("t_next_req",  obi_if.req, 1'b1);
            check_eq("t_next_addr", obi_if.addr, 32'h184);
            serve(32'h0, 1'b0, 32'h184);
            rsp_ack = 1'b1;
            tick();
            rsp_ack = 1'b0;
            check_eq("t_err_clear", timeout_err, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
